// File: rtl/nts_engine_scheduler_pkg.sv
// Shared types and constants for the nts_engine scheduler.
package nts_engine_scheduler_pkg;

  localparam int unsigned DATA_W             = 64;
  localparam int unsigned DV_W               = 8;
  localparam int unsigned WD_W               = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    RELEASE    = 2'd2,
    WAIT_CLEAR = 2'd3
  } sched_state_e;

endpackage

// File: rtl/nts_engine_scheduler_if.sv
// Signal bundle between one dispatcher RX FIFO, the scheduler and its engines.
interface nts_engine_scheduler_if
  import nts_engine_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 4
) ();

  logic                   dispatch_packet_available;
  logic                   dispatch_packet_read_discard;
  logic [DV_W-1:0]        dispatch_data_valid;
  logic                   dispatch_fifo_empty;
  logic                   dispatch_fifo_rd_en;
  logic [DATA_W-1:0]      dispatch_fifo_rd_data;
  logic [NUM_ENGINES-1:0] engine_busy;
  logic [NUM_ENGINES-1:0] engine_packet_available;
  logic [NUM_ENGINES-1:0] engine_packet_read_discard;
  logic [DV_W-1:0]        engine_data_valid;
  logic [NUM_ENGINES-1:0] engine_fifo_empty;
  logic [NUM_ENGINES-1:0] engine_fifo_rd_en;
  logic [DATA_W-1:0]      engine_fifo_rd_data;

  // Dispatcher side: owns the packet FIFO.
  modport master (
    output dispatch_packet_available, dispatch_data_valid,
           dispatch_fifo_empty, dispatch_fifo_rd_data,
    input  dispatch_packet_read_discard, dispatch_fifo_rd_en
  );

  // Engine side: consumes the packet presented by the scheduler.
  modport slave (
    output engine_busy, engine_packet_read_discard, engine_fifo_rd_en,
    input  engine_packet_available, engine_data_valid,
           engine_fifo_empty, engine_fifo_rd_data
  );

endinterface

// File: rtl/nts_rr_pick.sv
// Combinational round-robin picker: first set bit of idle at or above ptr, wrapping.
module nts_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     idle,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  int unsigned cand;

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!found_c && idle[cand]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/nts_engine_scheduler.sv
// Shares one dispatcher RX FIFO among NUM_ENGINES engines with a grant watchdog.
// Optional packet/timeout counters: define NTS_ENGINE_SCHEDULER_STATS_EN.
module nts_engine_scheduler
  import nts_engine_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ENGINES    = 4,
  parameter int unsigned ENGINE_W       = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   i_dispatch_packet_available,
  output logic                   o_dispatch_packet_read_discard,
  input  logic [DV_W-1:0]        i_dispatch_data_valid,
  input  logic                   i_dispatch_fifo_empty,
  output logic                   o_dispatch_fifo_rd_en,
  input  logic [DATA_W-1:0]      i_dispatch_fifo_rd_data,
  input  logic [NUM_ENGINES-1:0] i_engine_busy,
  output logic [NUM_ENGINES-1:0] o_engine_packet_available,
  input  logic [NUM_ENGINES-1:0] i_engine_packet_read_discard,
  output logic [DV_W-1:0]        o_engine_data_valid,
  output logic [NUM_ENGINES-1:0] o_engine_fifo_empty,
  input  logic [NUM_ENGINES-1:0] i_engine_fifo_rd_en,
  output logic [DATA_W-1:0]      o_engine_fifo_rd_data,
  output logic                   o_grant_valid,
  output logic [ENGINE_W-1:0]    o_grant_engine,
`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
  output logic [31:0]            o_stat_packets,
  output logic [31:0]            o_stat_timeouts,
`endif
  output logic                   o_timeout
);

  sched_state_e           state_q, state_d;
  logic [ENGINE_W-1:0]    grant_q, grant_d;
  logic [ENGINE_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_ENGINES-1:0] avail_q, avail_d;
  logic                   discard_q, discard_d;
  logic                   gvalid_q, gvalid_d;
  logic                   pick_found_c;
  logic [ENGINE_W-1:0]    pick_idx_c;
  logic [NUM_ENGINES-1:0] empty_c;
  logic                   rd_en_c;

  nts_rr_pick #(
    .N     (NUM_ENGINES),
    .IDX_W (ENGINE_W)
  ) u_rr_pick (
    .idle    (~i_engine_busy),
    .ptr     (rr_ptr_q),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  // Next-state logic; outputs are registered from the next-state view.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dispatch_packet_available && !i_dispatch_fifo_empty && pick_found_c) begin
          grant_d  = pick_idx_c;
          rr_ptr_d = (32'(pick_idx_c) == NUM_ENGINES - 1) ? '0 : pick_idx_c + ENGINE_W'(1);
          wd_d     = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        wd_d = wd_q + WD_W'(1);
        if (i_engine_packet_read_discard[grant_q]) begin
          state_d = RELEASE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = WAIT_CLEAR;
      WAIT_CLEAR: begin
        // Hold off until the dispatcher drops the released packet.
        if (!i_dispatch_packet_available) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    avail_d   = (state_d == GRANT) ? (NUM_ENGINES'(1) << grant_d) : '0;
    discard_d = (state_d == RELEASE);
    gvalid_d  = (state_d == GRANT) || (state_d == RELEASE);
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      avail_q   <= '0;
      discard_q <= 1'b0;
      gvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      avail_q   <= avail_d;
      discard_q <= discard_d;
      gvalid_q  <= gvalid_d;
    end
  end

  // FIFO read/empty path must track the live FIFO, so it bypasses the flops.
  always_comb begin
    empty_c = '1;
    rd_en_c = 1'b0;
    if (state_q == GRANT) begin
      empty_c[grant_q] = i_dispatch_fifo_empty;
      rd_en_c          = i_engine_fifo_rd_en[grant_q];
    end
  end

`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
  logic [31:0] stat_pkt_q, stat_pkt_d;
  logic [31:0] stat_to_q, stat_to_d;

  always_comb begin
    stat_pkt_d = stat_pkt_q;
    stat_to_d  = stat_to_q;
    if (state_q == GRANT && state_d == RELEASE) stat_pkt_d = stat_pkt_q + 32'd1;
    if (timeout_d)                              stat_to_d  = stat_to_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      stat_pkt_q <= '0;
      stat_to_q  <= '0;
    end else begin
      stat_pkt_q <= stat_pkt_d;
      stat_to_q  <= stat_to_d;
    end
  end

  assign o_stat_packets  = stat_pkt_q;
  assign o_stat_timeouts = stat_to_q;
`endif

  assign o_dispatch_packet_read_discard = discard_q;
  assign o_dispatch_fifo_rd_en          = rd_en_c;
  assign o_engine_packet_available      = avail_q;
  assign o_engine_data_valid            = i_dispatch_data_valid;
  assign o_engine_fifo_empty            = empty_c;
  assign o_engine_fifo_rd_data          = i_dispatch_fifo_rd_data;
  assign o_grant_valid                  = gvalid_q;
  assign o_grant_engine                 = grant_q;
  assign o_timeout                      = timeout_q;

endmodule

// File: tb/tb_nts_engine_scheduler.sv
// Directed bench for nts_engine_scheduler (4 engines, 10-cycle watchdog).
module tb_nts_engine_scheduler;
  import nts_engine_scheduler_pkg::*;

  localparam int unsigned NE = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  nts_engine_scheduler_if #(.NUM_ENGINES(NE)) bus ();

  logic                   grant_valid;
  logic [1:0]             grant_engine;
  logic                   timeout;
`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
  logic [31:0]            stat_packets;
  logic [31:0]            stat_timeouts;
`endif

  nts_engine_scheduler #(
    .NUM_ENGINES    (NE),
    .ENGINE_W       (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .i_clk                          (clk),
    .i_areset_n                     (rst_n),
    .i_dispatch_packet_available    (bus.dispatch_packet_available),
    .o_dispatch_packet_read_discard (bus.dispatch_packet_read_discard),
    .i_dispatch_data_valid          (bus.dispatch_data_valid),
    .i_dispatch_fifo_empty          (bus.dispatch_fifo_empty),
    .o_dispatch_fifo_rd_en          (bus.dispatch_fifo_rd_en),
    .i_dispatch_fifo_rd_data        (bus.dispatch_fifo_rd_data),
    .i_engine_busy                  (bus.engine_busy),
    .o_engine_packet_available      (bus.engine_packet_available),
    .i_engine_packet_read_discard   (bus.engine_packet_read_discard),
    .o_engine_data_valid            (bus.engine_data_valid),
    .o_engine_fifo_empty            (bus.engine_fifo_empty),
    .i_engine_fifo_rd_en            (bus.engine_fifo_rd_en),
    .o_engine_fifo_rd_data          (bus.engine_fifo_rd_data),
    .o_grant_valid                  (grant_valid),
    .o_grant_engine                 (grant_engine),
`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
    .o_stat_packets                 (stat_packets),
    .o_stat_timeouts                (stat_timeouts),
`endif
    .o_timeout                      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NE-1:0] busy;
    logic [NE-1:0] rd_en;
    logic [NE-1:0] dis;
    logic          fe;
    logic          exp_rd;
    logic [NE-1:0] exp_empty;
    logic [NE-1:0] exp_avail;
    logic          exp_rel;
  } vec_t;

  vec_t tbl [6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.dispatch_packet_available  = 1'b0;
    bus.dispatch_fifo_empty        = 1'b1;
    bus.engine_busy                = '0;
    bus.engine_fifo_rd_en          = '0;
    bus.engine_packet_read_discard = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic present();
    bus.dispatch_packet_available = 1'b1;
    bus.dispatch_fifo_empty       = 1'b0;
  endtask

  task automatic withdraw();
    bus.dispatch_packet_available = 1'b0;
    bus.dispatch_fifo_empty       = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic run_packet(input int g);
    present();
    cyc();
    chk("rr_engine", 64'(grant_engine), 64'(g));
    chk("rr_avail", 64'(bus.engine_packet_available), 64'(1) << g);
    bus.engine_packet_read_discard = NE'(1 << g);
    cyc();
    bus.engine_packet_read_discard = '0;
    chk("rr_release", 64'(bus.dispatch_packet_read_discard), 64'd1);
    withdraw();
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;
    bus.dispatch_data_valid   = 8'h3C;
    bus.dispatch_fifo_rd_data = 64'h0123_4567_89AB_CDEF;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_avail", 64'(bus.engine_packet_available), 64'h0);
    chk("rst_discard", 64'(bus.dispatch_packet_read_discard), 64'h0);
    chk("rst_rd_en", 64'(bus.dispatch_fifo_rd_en), 64'h0);
    chk("rst_empty", 64'(bus.engine_fifo_empty), 64'hF);
    chk("rst_gvalid", 64'(grant_valid), 64'h0);
    chk("rst_gengine", 64'(grant_engine), 64'h0);
    chk("rst_timeout", 64'(timeout), 64'h0);
    chk("bcast_dv", 64'(bus.engine_data_valid), 64'h3C);
    chk("bcast_data", bus.engine_fifo_rd_data, 64'h0123_4567_89AB_CDEF);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Basic grant: three reads then discard from engine 0
    present();
    #1;
    chk("basic_not_yet", 64'(bus.engine_packet_available), 64'h0);
    cyc();
    chk("basic_avail", 64'(bus.engine_packet_available), 64'b0001);
    chk("basic_gvalid", 64'(grant_valid), 64'd1);
    chk("basic_gengine", 64'(grant_engine), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.engine_fifo_rd_en = 4'b0001;
      #1;
      chk("basic_rd_en", 64'(bus.dispatch_fifo_rd_en), 64'd1);
      chk("basic_empty", 64'(bus.engine_fifo_empty), 64'b1110);
      cyc();
    end
    bus.engine_fifo_rd_en          = '0;
    bus.engine_packet_read_discard = 4'b0001;
    #1;
    chk("basic_discard_early", 64'(bus.dispatch_packet_read_discard), 64'd0);
    cyc();
    bus.engine_packet_read_discard = '0;
    bus.engine_fifo_rd_en          = 4'b0001;
    #1;
    chk("basic_discard", 64'(bus.dispatch_packet_read_discard), 64'd1);
    chk("release_avail", 64'(bus.engine_packet_available), 64'd0);
    chk("release_rd_forced", 64'(bus.dispatch_fifo_rd_en), 64'd0);
    chk("release_gvalid", 64'(grant_valid), 64'd1);
    cyc();
    bus.engine_fifo_rd_en = '0;
    chk("discard_one_cycle", 64'(bus.dispatch_packet_read_discard), 64'd0);
    chk("wait_gvalid", 64'(grant_valid), 64'd0);
    repeat (3) cyc();
    chk("no_double_grant", 64'(bus.engine_packet_available), 64'd0);
`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
    chk("stat_packets", 64'(stat_packets), 64'd1);
    chk("stat_timeouts", 64'(stat_timeouts), 64'd0);
`endif
    withdraw();

    // Round robin with all idle, then with engine 1 busy
    do_reset();
    run_packet(0);
    run_packet(1);
    run_packet(2);
    do_reset();
    bus.engine_busy = 4'b0010;
    run_packet(0);
    run_packet(2);
    run_packet(3);

    // All busy for 50 cycles, then engine 2 frees up
    do_reset();
    bus.engine_busy = 4'b1111;
    present();
    k = 0;
    repeat (50) begin
      cyc();
      if (grant_valid !== 1'b0 || bus.engine_packet_available !== 4'b0000) k++;
    end
    chk("all_busy_grants", 64'(k), 64'd0);
    bus.engine_busy = 4'b1011;
    cyc();
    chk("busy_drop_avail", 64'(bus.engine_packet_available), 64'b0100);
    chk("busy_drop_engine", 64'(grant_engine), 64'd2);
    bus.engine_busy = 4'b1111;
    cyc();
    chk("busy_in_grant", 64'(bus.engine_packet_available), 64'b0100);
    bus.engine_packet_read_discard = 4'b0100;
    cyc();
    bus.engine_packet_read_discard = '0;
    chk("busy_release", 64'(bus.dispatch_packet_read_discard), 64'd1);
    bus.engine_busy = '0;
    withdraw();

    // Watchdog expiry with no discard
    do_reset();
    present();
    cyc();
    chk("wd_grant", 64'(grant_valid), 64'd1);
    k = 0;
    while (timeout !== 1'b1 && k < 30) begin
      cyc();
      k++;
    end
    chk("wd_latency", 64'(k), 64'd10);
    chk("wd_forced_discard", 64'(bus.dispatch_packet_read_discard), 64'd1);
    cyc();
    chk("wd_timeout_pulse", 64'(timeout), 64'd0);
    chk("wd_discard_pulse", 64'(bus.dispatch_packet_read_discard), 64'd0);
    withdraw();

    // Discard coinciding with the last watchdog cycle
    do_reset();
    present();
    cyc();
    repeat (9) cyc();
    chk("tie_still_granted", 64'(bus.engine_packet_available), 64'b0001);
    bus.engine_packet_read_discard = 4'b0001;
    cyc();
    bus.engine_packet_read_discard = '0;
    chk("tie_discard", 64'(bus.dispatch_packet_read_discard), 64'd1);
    chk("tie_no_timeout", 64'(timeout), 64'd0);
    cyc();
    chk("tie_no_timeout_late", 64'(timeout), 64'd0);
    withdraw();

    // Isolation table with engine 1 granted
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0010, 1'b0};
    tbl[1] = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 1'b0};
    tbl[2] = '{4'b1111, 4'b1101, 4'b1101, 1'b0, 1'b0, 4'b1101, 4'b0010, 1'b0};
    tbl[3] = '{4'b0010, 4'b0011, 4'b0001, 1'b1, 1'b1, 4'b1111, 4'b0010, 1'b0};
    tbl[4] = '{4'b0000, 4'b0100, 4'b1000, 1'b1, 1'b0, 4'b1111, 4'b0010, 1'b0};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b1};
    do_reset();
    bus.engine_busy = 4'b0001;
    present();
    cyc();
    chk("iso_engine", 64'(grant_engine), 64'd1);
    for (int i = 0; i < 6; i++) begin
      bus.engine_busy                = tbl[i].busy;
      bus.engine_fifo_rd_en          = tbl[i].rd_en;
      bus.engine_packet_read_discard = tbl[i].dis;
      bus.dispatch_fifo_empty        = tbl[i].fe;
      #1;
      chk($sformatf("iso%0d_rd_en", i), 64'(bus.dispatch_fifo_rd_en), 64'(tbl[i].exp_rd));
      chk($sformatf("iso%0d_empty", i), 64'(bus.engine_fifo_empty), 64'(tbl[i].exp_empty));
      cyc();
      chk($sformatf("iso%0d_avail", i), 64'(bus.engine_packet_available), 64'(tbl[i].exp_avail));
      chk($sformatf("iso%0d_rel", i), 64'(bus.dispatch_packet_read_discard), 64'(tbl[i].exp_rel));
    end
    bus.engine_packet_read_discard = '0;
    bus.engine_fifo_rd_en          = 4'b0010;
    #1;
    chk("iso_release_rd", 64'(bus.dispatch_fifo_rd_en), 64'd0);
    bus.engine_fifo_rd_en = '0;
    bus.engine_busy       = '0;
    withdraw();

    // Asynchronous reset in the middle of a grant to engine 2
    do_reset();
    bus.engine_busy = 4'b0011;
    present();
    cyc();
    chk("mid_engine", 64'(grant_engine), 64'd2);
    bus.engine_fifo_rd_en = 4'b0100;
    #1;
    chk("mid_rd_en", 64'(bus.dispatch_fifo_rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_avail", 64'(bus.engine_packet_available), 64'd0);
    chk("mid_rst_gvalid", 64'(grant_valid), 64'd0);
    chk("mid_rst_gengine", 64'(grant_engine), 64'd0);
    chk("mid_rst_empty", 64'(bus.engine_fifo_empty), 64'hF);
    chk("mid_rst_rd_en", 64'(bus.dispatch_fifo_rd_en), 64'd0);
    bus.engine_busy       = '0;
    bus.engine_fifo_rd_en = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_engine", 64'(grant_engine), 64'd0);
    chk("post_rst_avail", 64'(bus.engine_packet_available), 64'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nts_engine_scheduler.md
Name: nts_engine_scheduler

Overview:
- Shares one dispatcher RX FIFO interface between NUM_ENGINES nts_engine instances.
- Picks an idle engine round-robin and presents the pending packet to that engine only.
- Muxes the granted engine's FIFO reads and discard back to the dispatcher.
- Runs a watchdog that force-discards a packet if the granted engine never releases it.

Parameters:
- NUM_ENGINES, 4, number of engines served (2..16).
- ENGINE_W, 2, width of engine index; must equal clog2(NUM_ENGINES).
- TIMEOUT_CYCLES, 16'd4000, cycles a grant may last before forced discard (must be >0).

Ports:
- i_clk  in  1  clock.
- i_areset_n  in  1  asynchronous reset, active-low.
- i_dispatch_packet_available  in  1  dispatcher has a complete packet.
- o_dispatch_packet_read_discard  out  1  one-cycle pulse releasing the packet.
- i_dispatch_data_valid  in  8  last-word byte-valid mask.
- i_dispatch_fifo_empty  in  1  dispatcher FIFO empty.
- o_dispatch_fifo_rd_en  out  1  FIFO read strobe.
- i_dispatch_fifo_rd_data  in  64  FIFO read data.
- i_engine_busy  in  NUM_ENGINES  per-engine busy.
- o_engine_packet_available  out  NUM_ENGINES  packet presented, one-hot or zero.
- i_engine_packet_read_discard  in  NUM_ENGINES  per-engine discard pulse.
- o_engine_data_valid  out  8  broadcast copy of i_dispatch_data_valid.
- o_engine_fifo_empty  out  NUM_ENGINES  per-engine empty view.
- i_engine_fifo_rd_en  in  NUM_ENGINES  per-engine read strobe.
- o_engine_fifo_rd_data  out  64  broadcast copy of i_dispatch_fifo_rd_data.
- o_grant_valid  out  1  a grant is active.
- o_grant_engine  out  ENGINE_W  index of the granted engine.
- o_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset state (async, i_areset_n=0):
  - State IDLE, rr_ptr=0, watchdog=0.
  - All outputs 0, except o_engine_fifo_empty, which is all-ones.
- States: IDLE, GRANT, RELEASE, WAIT_CLEAR.
- IDLE:
  - Leave when i_dispatch_packet_available && !i_dispatch_fifo_empty && at least one engine has i_engine_busy=0.
  - Select the first idle engine searching from rr_ptr upward, with wrap-around.
  - Register grant_engine, set rr_ptr = grant_engine+1 (mod NUM_ENGINES), go to GRANT.
  - Latency: o_engine_packet_available[g] rises 1 cycle after the qualifying condition is seen.
- GRANT:
  - o_engine_packet_available = one-hot(g).
  - o_engine_fifo_empty[g] = i_dispatch_fifo_empty; all other bits are 1.
  - o_dispatch_fifo_rd_en = i_engine_fifo_rd_en[g], combinational; rd_en from non-granted engines is ignored.
  - Watchdog counts up by 1 each cycle.
  - If i_engine_packet_read_discard[g]=1: go to RELEASE.
  - Else, if the watchdog reaches TIMEOUT_CYCLES-1: pulse o_timeout and go to RELEASE.
  - If discard and timeout occur in the same cycle, the discard wins and o_timeout is not pulsed.
- RELEASE:
  - o_dispatch_packet_read_discard=1 for exactly one cycle.
  - o_engine_packet_available goes to 0 and o_dispatch_fifo_rd_en is forced to 0.
  - Go to WAIT_CLEAR.
- WAIT_CLEAR:
  - No grant; return to IDLE when i_dispatch_packet_available=0.
  - Prevents a double grant of the same packet.
- Discard pulses from non-granted engines are ignored in every state.
- Busy handling:
  - All engines busy in IDLE: stay in IDLE, no grant.
  - i_engine_busy changing during GRANT has no effect.
- o_grant_valid=1 in GRANT and RELEASE.
- o_grant_engine holds its value until the next grant.
- Reset asserted mid-GRANT: immediate return to reset values. The dispatcher is responsible for its own reset.

Optional Feature:
- Macro NTS_ENGINE_SCHEDULER_STATS_EN.
- When defined, adds outputs:
  - o_stat_packets (32 bit): increments on each RELEASE entry.
  - o_stat_timeouts (32 bit): increments on each o_timeout pulse.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package nts_engine_scheduler_pkg holds:
  - State encodings: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2, WAIT_CLEAR=2'd3.
  - Default TIMEOUT_CYCLES.
- One sub-module, nts_rr_pick:
  - Combinational.
  - Inputs: idle vector and rr_ptr. Outputs: found flag and selected index.
  - Reusable by future schedulers.

Test Plan:
- Basic grant:
  - Stimulus: all idle, rr_ptr=0, packet available, FIFO non-empty.
  - Response: o_engine_packet_available=4'b0001 next cycle. Engine 0 reads 3 words via rd_en, then discards. o_dispatch_packet_read_discard pulses once, 1 cycle later.
- Round robin:
  - Stimulus: three back-to-back packets, all engines idle.
  - Response: grants go to engines 0, 1, 2 in order.
  - Stimulus: with engine 1 busy, three packets.
  - Response: grants go to 0, 2, 3.
- All busy:
  - Stimulus: i_engine_busy=4'b1111 with a packet available for 50 cycles.
  - Response: no grant. Granting engine 2 follows within 1 cycle after its busy bit drops.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=10, granted engine never discards.
  - Response: o_timeout and forced discard pulse 10 cycles after the grant.
  - Stimulus: discard and timeout in the same cycle.
  - Response: discard pulse only, no o_timeout.
- Isolation:
  - Stimulus: non-granted engine asserts rd_en and discard during GRANT.
  - Response: o_dispatch_fifo_rd_en=0 and no discard pulse. Its o_engine_fifo_empty bit stays 1.
- Reset mid-grant:
  - Stimulus: assert i_areset_n=0 during GRANT.
  - Response: all outputs go to reset values asynchronously. After release, the first grant goes to engine 0.
